// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM pipeline stage.
//   - access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD; size 3 is treated as word)
//   - FSM state type for the data-memory access sequencer
//   - default WB control bundle width
//   - byte-strobe constants
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_e;

    localparam int unsigned WB_W_DEF = 10;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_LO_HALF = 4'b0011;
    localparam logic [3:0] STRB_HI_HALF = 4'b1100;
    localparam logic [3:0] STRB_ALL     = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic for the MEM stage.
// Store side (from the EX/MEM slot):
//   st_addr_lo, st_size, st_wdata -> st_strb, st_data (lane-replicated), misalign
// Load side (from the captured access):
//   ld_addr_lo, ld_size, ld_sign, ld_rdata -> ld_data (lane-extracted, extended)
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  st_strb,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_strb  = STRB_ALL;
        st_data  = st_wdata;
        misalign = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                st_strb = 4'b0001 << st_addr_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_strb  = st_addr_lo[1] ? STRB_HI_HALF : STRB_LO_HALF;
                st_data  = {2{st_wdata[15:0]}};
                misalign = st_addr_lo[0];
            end
            default: begin
                misalign = |st_addr_lo;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Consumes the EX/MEM slot (ex_*), runs a req/ack data-memory access (dm_*),
// stalls upstream while an access is outstanding (mem_stall) and presents
// registered results to MEM/WB (wb_*).
// Optional: define DMEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// un-acked BUSY cycles and report wb_bus_err; otherwise BUSY waits forever.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned WB_W           = WB_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_size,
    input  logic            ex_sign,
    input  logic [31:0]     ex_addr,
    input  logic [31:0]     ex_wdata,
    input  logic [WB_W-1:0] ex_wb_ctrl,
    output logic            dm_req,
    output logic            dm_we,
    output logic [31:0]     dm_addr,
    output logic [3:0]      dm_wstrb,
    output logic [31:0]     dm_wdata,
    input  logic            dm_ack,
    input  logic [31:0]     dm_rdata,
    output logic            mem_stall,
    output logic            wb_valid,
    output logic [31:0]     wb_rdata,
    output logic [31:0]     wb_alu,
    output logic [WB_W-1:0] wb_ctrl,
    output logic            wb_misalign,
    output logic            wb_bus_err
);

    mem_state_e state_q, state_d;

    // Access captured on the IDLE->BUSY transition; drives dm_* while BUSY.
    logic [31:0]     addr_q;
    logic            we_q;
    logic [3:0]      strb_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic [WB_W-1:0] ctrl_q;

    logic            wb_valid_d, wb_valid_q;
    logic [31:0]     wb_rdata_d, wb_rdata_q;
    logic [31:0]     wb_alu_d, wb_alu_q;
    logic [WB_W-1:0] wb_ctrl_d, wb_ctrl_q;
    logic            wb_misalign_d, wb_misalign_q;
    logic            wb_bus_err_d, wb_bus_err_q;

    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        misalign;
    logic        is_mem;
    logic        start;
    logic        fault;
    logic        timeout;

    mem_lane_align u_align (
        .st_addr_lo (ex_addr[1:0]),
        .st_size    (ex_size),
        .st_wdata   (ex_wdata),
        .ld_addr_lo (addr_q[1:0]),
        .ld_size    (size_q),
        .ld_sign    (sign_q),
        .ld_rdata   (dm_rdata),
        .st_strb    (st_strb),
        .st_data    (st_data),
        .ld_data    (ld_data),
        .misalign   (misalign)
    );

    assign is_mem = ex_mem_read | ex_mem_write;
    assign start  = (state_q == IDLE) & ex_valid & is_mem & ~misalign;
    assign fault  = (state_q == IDLE) & ex_valid & is_mem & misalign;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter is zero on BUSY entry; an ack in the expiring cycle wins.
    assign cnt_d   = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
    assign timeout = (state_q == BUSY) & ~dm_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (dm_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        dm_req    = (state_q == BUSY);
        mem_stall = (state_q == BUSY);
    end

    assign dm_we    = we_q;
    assign dm_addr  = {addr_q[31:2], 2'b00};
    assign dm_wstrb = strb_q;
    assign dm_wdata = wdata_q;

    // MEM/WB result for this cycle; a bubble leaves everything zero.
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_rdata_d    = '0;
        wb_alu_d      = '0;
        wb_ctrl_d     = '0;
        wb_misalign_d = 1'b0;
        wb_bus_err_d  = 1'b0;
        if (state_q == IDLE) begin
            if (ex_valid && !is_mem) begin
                wb_valid_d = 1'b1;
                wb_alu_d   = ex_addr;
                wb_ctrl_d  = ex_wb_ctrl;
            end else if (fault) begin
                wb_valid_d    = 1'b1;
                wb_alu_d      = ex_addr;
                wb_misalign_d = 1'b1;
            end
        end else if (dm_ack) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = addr_q;
            wb_ctrl_d  = ctrl_q;
            wb_rdata_d = we_q ? 32'h0 : ld_data;
        end else if (timeout) begin
            wb_valid_d   = 1'b1;
            wb_alu_d     = addr_q;
            wb_bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            we_q          <= 1'b0;
            strb_q        <= STRB_NONE;
            wdata_q       <= '0;
            size_q        <= SZ_BYTE;
            sign_q        <= 1'b0;
            ctrl_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
            wb_ctrl_q     <= '0;
            wb_misalign_q <= 1'b0;
            wb_bus_err_q  <= 1'b0;
        end else begin
            if (start) begin
                // Write wins when both read and write are flagged.
                addr_q  <= ex_addr;
                we_q    <= ex_mem_write;
                strb_q  <= ex_mem_write ? st_strb : STRB_NONE;
                wdata_q <= ex_mem_write ? st_data : 32'h0;
                size_q  <= ex_size;
                sign_q  <= ex_sign;
                ctrl_q  <= ex_wb_ctrl;
            end
            wb_valid_q    <= wb_valid_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_alu_q      <= wb_alu_d;
            wb_ctrl_q     <= wb_ctrl_d;
            wb_misalign_q <= wb_misalign_d;
            wb_bus_err_q  <= wb_bus_err_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_rdata    = wb_rdata_q;
    assign wb_alu      = wb_alu_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign wb_misalign = wb_misalign_q;
    assign wb_bus_err  = wb_bus_err_q;

endmodule
